// File: rtl/mdu_pkg.sv
// mdu_pkg
//   Shared definitions for the iterative multiply/divide unit:
//   operation encodings, FSM state encoding and the divide-by-zero
//   quotient constant.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative multiply/divide unit producing HI/LO one result bit per cycle.
//   Multiply is a shift-add over magnitudes, divide is restoring division
//   over magnitudes; sign correction and special cases are applied in FIX.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-low reset
//   start  in   operation request, sampled only in IDLE
//   op     in   2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU
//   A, B   in   operands (multiplicand/dividend, multiplier/divisor)
//   hi_we  in   MTHI strobe (IDLE only)
//   lo_we  in   MTLO strobe (IDLE only)
//   wd     in   MTHI/MTLO write data
//   busy   out  high while iterating
//   done   out  one-cycle pulse when hi/lo hold a new result
//   hi, lo out  HI/LO registers
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mdu_pkg::*;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state, state_next;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_orig, mag_a, mag_b;
  logic               sign_a, sign_b;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   acc, acc_next;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  logic               in_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     sum, trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  // Magnitudes of the incoming operands. op[0]==0 marks the signed ops.
  // -A of the most negative value wraps back to itself, which read as
  // unsigned is exactly 2^(WIDTH-1), so no overflow case is needed here.
  assign in_signed = ~op[0];
  assign a_neg     = in_signed & A[WIDTH-1];
  assign b_neg     = in_signed & B[WIDTH-1];
  assign a_abs     = a_neg ? -A : A;
  assign b_abs     = b_neg ? -B : B;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH-1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // One iteration. Multiply: the accumulator's upper WIDTH+1 bits hold the
  // partial product with its carry; the lower half holds the remaining
  // multiplier bits. Divide: acc[2W-1:W] is the remainder, acc[W-1:0] the
  // dividend shifting out as quotient bits shift in.
  always_comb begin
    acc_next = acc;
    sum      = '0;
    trial    = '0;
    if (op_q[1]) begin
      trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
      if (!trial[WIDTH])
        acc_next = {1'b0, trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {acc[2*WIDTH-1:0], 1'b0};
    end else begin
      sum = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, mag_a}) : acc[2*WIDTH:WIDTH];
      acc_next = {1'b0, sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q   <= OP_MULT;
      a_orig <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            a_orig <= A;
            mag_a  <= a_abs;
            mag_b  <= b_abs;
            sign_a <= a_neg;
            sign_b <= b_neg;
            cnt    <= '0;
            acc    <= {{(WIDTH+1){1'b0}}, (op[1] ? a_abs : b_abs)};
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Sign correction and special cases. Sign flags are only ever set for
  // the signed ops, so the unsigned ops pass straight through. The divide
  // overflow case is recognised as dividend MIN_NEG with divisor -1.
  always_comb begin
    prod   = acc[2*WIDTH-1:0];
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    fix_hi = '0;
    fix_lo = '0;
    if (!op_q[1]) begin
      if (sign_a ^ sign_b) {fix_hi, fix_lo} = -prod;
      else                 {fix_hi, fix_lo} = prod;
    end else if (mag_b == '0) begin
      fix_hi = a_orig;
      fix_lo = DIV0_LO;
    end else if (op_q == OP_DIV && a_orig == MIN_NEG && sign_b && mag_b == WIDTH'(1)) begin
      fix_hi = '0;
      fix_lo = MIN_NEG;
    end else begin
      fix_lo = (sign_a ^ sign_b) ? -quo : quo;
      fix_hi = sign_a ? -rem : rem;
    end
  end

  // HI/LO and the done pulse. MTHI/MTLO act only in IDLE; a start in the
  // same cycle is still accepted and FIX later overwrites both registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (state == FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end else if (state == IDLE) begin
        if (hi_we) hi <= wd;
        if (lo_we) lo <= wd;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit: a table of directed vectors,
//   randomized operations against an arithmetic reference model, and
//   hand-written handshake, MTHI/MTLO and reset-abort sequences.
module tb_mult_div_unit;

  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] A, B, wd;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Hard stop in case some wait is never satisfied.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation and waits (bounded) for done. lat counts edges
  // from the start edge to the edge that raised done; busy_cnt counts
  // sampled cycles with busy high.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output int busy_cnt);
    op = o; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    lat = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  function automatic void refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    rh = '0;
    rl = '0;
    case (o)
      OP_MULT:  begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          rh = a;
          rl = 32'hFFFF_FFFF;
        end else begin
          if (o == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'({32'b0, a}) / longint'({32'b0, b});
            r = longint'({32'b0, a}) % longint'({32'b0, b});
          end
          rl = q[31:0];
          rh = r[31:0];
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h7FFF_FFFF;
      4: v = 32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int          lat, busy_cnt, done_cnt;
    logic [31:0] exp_hi, exp_lo, cap_hi, cap_lo;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{"multu_7x3",      OP_MULTU, 32'd7,          32'd3,          32'd0,          32'd21};
    vecs[1] = '{"mult_m2x5",      OP_MULT,  32'hFFFF_FFFE,  32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFF6};
    vecs[2] = '{"multu_max",      OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1};
    vecs[3] = '{"div_m7_2",       OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD};
    vecs[4] = '{"divu_100_7",     OP_DIVU,  32'd100,        32'd7,          32'd2,          32'd14};
    vecs[5] = '{"divu_by0",       OP_DIVU,  32'd9,          32'd0,          32'd9,          32'hFFFF_FFFF};
    vecs[6] = '{"div_ovf",        OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[7] = '{"div_by0_neg",    OP_DIV,   32'h8000_0000,  32'd0,          32'h8000_0000,  32'hFFFF_FFFF};
    vecs[8] = '{"mult_min_min",   OP_MULT,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32'd0};
    vecs[9] = '{"div_7_m2",       OP_DIV,   32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD};

    reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = OP_MULT; A = '0; B = '0; wd = '0;
    repeat (3) tick();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    reset = 1'b1;
    tick();

    // Directed table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_cnt);
      checkOutput({vecs[i].name, "_latency"}, 32'(lat), 32'd33);
      checkOutput({vecs[i].name, "_busycycles"}, 32'(busy_cnt), 32'd32);
      checkOutput({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      checkOutput({vecs[i].name, "_lo"}, lo, vecs[i].lo);
      tick();
      checkOutput({vecs[i].name, "_donepulse"}, 32'(done), 32'd0);
    end

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      refModel(rop, ra, rb, exp_hi, exp_lo);
      applyStimulus(rop, ra, rb, lat, busy_cnt);
      checkOutput($sformatf("rand%0d_op%0d_%h_%h_hi", n, rop, ra, rb), hi, exp_hi);
      checkOutput($sformatf("rand%0d_op%0d_%h_%h_lo", n, rop, ra, rb), lo, exp_lo);
      checkOutput($sformatf("rand%0d_latency", n), 32'(lat), 32'd33);
    end

    // Start and MTHI mid-run are ignored; exactly one done
    op = OP_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0; cap_hi = '0; cap_lo = '0;
    for (int i = 0; i < 45; i++) begin
      if (i == 5) begin
        start = 1'b1; op = OP_MULT; A = 32'd3; B = 32'd3; hi_we = 1'b1; wd = 32'hABCD;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      tick();
      if (done === 1'b1) begin
        done_cnt++;
        cap_hi = hi;
        cap_lo = lo;
      end
    end
    checkOutput("midrun_done_count", 32'(done_cnt), 32'd1);
    checkOutput("midrun_hi", cap_hi, 32'd2);
    checkOutput("midrun_lo", cap_lo, 32'd14);
    checkOutput("midrun_hold_hi", hi, 32'd2);
    checkOutput("midrun_hold_lo", lo, 32'd14);

    // MTLO / MTHI in IDLE
    wd = 32'd5; lo_we = 1'b1;
    tick();
    lo_we = 1'b0;
    checkOutput("mtlo_lo", lo, 32'd5);
    checkOutput("mtlo_hi_untouched", hi, 32'd2);
    wd = 32'd77; hi_we = 1'b1; lo_we = 1'b1;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    checkOutput("mtboth_hi", hi, 32'd77);
    checkOutput("mtboth_lo", lo, 32'd77);

    // Strobe coinciding with start: write lands, result overwrites later
    wd = 32'd123; lo_we = 1'b1;
    op = OP_MULTU; A = 32'd7; B = 32'd3; start = 1'b1;
    tick();
    lo_we = 1'b0; start = 1'b0;
    checkOutput("coincide_lo_written", lo, 32'd123);
    checkOutput("coincide_busy", 32'(busy), 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    checkOutput("coincide_latency", 32'(lat), 32'd33);
    checkOutput("coincide_lo_result", lo, 32'd21);

    // Reset in the middle of an operation
    op = OP_MULTU; A = 32'd7; B = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b0;
    tick();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    reset = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
    applyStimulus(OP_MULTU, 32'd7, 32'd3, lat, busy_cnt);
    checkOutput("after_abort_latency", 32'(lat), 32'd33);
    checkOutput("after_abort_hi", hi, 32'd0);
    checkOutput("after_abort_lo", lo, 32'd21);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
